// File: rtl/vga_frame_sched_if.sv
// Sprite-position update handshake between a requester and the frame scheduler.
//   cfg_req   requester -> scheduler  update request, held until cfg_ack
//   cfg_xpos  requester -> scheduler  requested x, stable while cfg_req is high
//   cfg_ypos  requester -> scheduler  requested y, stable while cfg_req is high
//   cfg_ack   scheduler -> requester  1-cycle pulse: new position now visible
// master = requester side, slave = scheduler side.
interface vga_frame_sched_if #(
  parameter int POS_W = 11
);
  logic             cfg_req;
  logic [POS_W-1:0] cfg_xpos;
  logic [POS_W-1:0] cfg_ypos;
  logic             cfg_ack;

  modport master (output cfg_req, output cfg_xpos, output cfg_ypos, input cfg_ack);
  modport slave  (input cfg_req, input cfg_xpos, input cfg_ypos, output cfg_ack);
endinterface

// File: rtl/vga_frame_sched.sv
// Frame scheduler for the 800x600@60 VGA path (40 MHz pixel clock).
// Owns the pixel/line counters, produces registered blank/sync flags and a
// frame-start pulse, starts scanout on request and stops it only at a frame
// boundary. Sprite position updates are committed at the start of vblank (or
// immediately while idle) so the draw stages never see a mid-frame change.
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   en                 1 = run scanout, 0 = stop at end of current frame
//   hcount, vcount     pixel / line index of the current cycle
//   hblnk, vblnk       blank flags, aligned with the counts
//   hsync, vsync       sync pulses, active-high
//   frame_start        1-cycle pulse at count 0/0 while running
//   xpos, ypos         committed sprite position
//   busy               1 while not idle
//   cfg                position update handshake (slave side)
module vga_frame_sched #(
  parameter int HTOTAL  = 1056,
  parameter int HBLK_S  = 800,
  parameter int HSYNC_S = 840,
  parameter int HSYNC_E = 968,
  parameter int VTOTAL  = 628,
  parameter int VBLK_S  = 600,
  parameter int VSYNC_S = 601,
  parameter int VSYNC_E = 605,
  parameter int POS_W   = 11,
  parameter int X_RST   = 0,
  parameter int Y_RST   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [10:0]      hcount,
  output logic [10:0]      vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             busy,
  vga_frame_sched_if.slave cfg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [10:0] HLAST = 11'(HTOTAL - 1);
  localparam logic [10:0] VLAST = 11'(VTOTAL - 1);
  localparam logic [10:0] HBLK  = 11'(HBLK_S);
  localparam logic [10:0] HSS   = 11'(HSYNC_S);
  localparam logic [10:0] HSE   = 11'(HSYNC_E);
  localparam logic [10:0] VBLK  = 11'(VBLK_S);
  localparam logic [10:0] VSS   = 11'(VSYNC_S);
  localparam logic [10:0] VSE   = 11'(VSYNC_E);

  state_t           state, state_n;
  logic [10:0]      h_n, v_n;
  logic             last_px;
  logic             commit;
  logic             accept;
  logic             pending;
  logic             ack_q;
  logic [POS_W-1:0] x_shadow, y_shadow;

  assign last_px = (hcount == HLAST) && (vcount == VLAST);
  assign accept  = cfg.cfg_req && !pending;
  assign cfg.cfg_ack = ack_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // DRAIN keeps counting; re-asserting en before the last pixel resumes RUN
  // without disturbing the counts.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (en) state_n = RUN;
      RUN:     if (!en) state_n = DRAIN;
      DRAIN:   if (en) state_n = RUN;
               else if (last_px) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    commit = (state == IDLE) || ((hcount == 11'd0) && (vcount == VBLK));
  end

  // Next counts: leaving IDLE shows 0/0 first, entering IDLE forces 0/0.
  always_comb begin
    h_n = 11'd0;
    v_n = 11'd0;
    if ((state != IDLE) && (state_n != IDLE)) begin
      if (hcount == HLAST) begin
        h_n = 11'd0;
        v_n = (vcount == VLAST) ? 11'd0 : vcount + 11'd1;
      end else begin
        h_n = hcount + 11'd1;
        v_n = vcount;
      end
    end
  end

  // Flags are computed from the next counts so they land on the same cycle
  // as the counts they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_n;
      vcount      <= v_n;
      hblnk       <= (state_n != IDLE) && (h_n >= HBLK);
      vblnk       <= (state_n != IDLE) && (v_n >= VBLK);
      hsync       <= (state_n != IDLE) && (h_n >= HSS) && (h_n < HSE);
      vsync       <= (state_n != IDLE) && (v_n >= VSS) && (v_n < VSE);
      frame_start <= (state_n != IDLE) && (h_n == 11'd0) && (v_n == 11'd0);
    end
  end

  // A request accepted on a commit cycle has pending=0 there, so it is not
  // committed until the next commit point.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      ack_q   <= 1'b0;
      xpos    <= POS_W'(X_RST);
      ypos    <= POS_W'(Y_RST);
    end else begin
      ack_q <= 1'b0;
      if (commit && pending) begin
        xpos    <= x_shadow;
        ypos    <= y_shadow;
        ack_q   <= 1'b1;
        pending <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_shadow <= cfg.cfg_xpos;
      y_shadow <= cfg.cfg_ypos;
    end
  end

endmodule

// File: tb/tb_vga_frame_sched.sv
// Bench for vga_frame_sched. A shrunken-timing instance exercises complete
// frames, stop/resume and the position handshake; a default-timing instance
// checks the real 800x600 horizontal line timing.
module tb_vga_frame_sched;

  localparam int S_HT = 20, S_HB = 12, S_HS = 14, S_HE = 17;
  localparam int S_VT = 12, S_VB = 8,  S_VS = 9,  S_VE = 11;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic clk, rst, en, en_d;
  logic [10:0] h_s, v_s, h_d, v_d;
  logic hb_s, vb_s, hs_s, vs_s, fs_s, busy_s;
  logic hb_d, vb_d, hs_d, vs_d, fs_d, busy_d;
  logic [10:0] xpos_s, ypos_s, xpos_d, ypos_d;

  int n_vec = 0;
  int n_err = 0;
  int mst, eh, ev;

  vga_frame_sched_if #(.POS_W(11)) cfg_s ();
  vga_frame_sched_if #(.POS_W(11)) cfg_d ();

  vga_frame_sched #(
    .HTOTAL(S_HT), .HBLK_S(S_HB), .HSYNC_S(S_HS), .HSYNC_E(S_HE),
    .VTOTAL(S_VT), .VBLK_S(S_VB), .VSYNC_S(S_VS), .VSYNC_E(S_VE),
    .POS_W(11), .X_RST(0), .Y_RST(0)
  ) u_s (
    .clk(clk), .rst(rst), .en(en), .hcount(h_s), .vcount(v_s),
    .hblnk(hb_s), .vblnk(vb_s), .hsync(hs_s), .vsync(vs_s),
    .frame_start(fs_s), .xpos(xpos_s), .ypos(ypos_s), .busy(busy_s),
    .cfg(cfg_s.slave)
  );

  vga_frame_sched u_d (
    .clk(clk), .rst(rst), .en(en_d), .hcount(h_d), .vcount(v_d),
    .hblnk(hb_d), .vblnk(vb_d), .hsync(hs_d), .vsync(vs_d),
    .frame_start(fs_d), .xpos(xpos_d), .ypos(ypos_d), .busy(busy_d),
    .cfg(cfg_d.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected behaviour of the small instance, advanced once per clock edge.
  task automatic tick_s();
    @(posedge clk);
    #1;
    if (mst == M_IDLE) begin
      if (en) begin
        mst = M_RUN; eh = 0; ev = 0;
      end
    end else if (mst == M_DRAIN && !en && eh == S_HT-1 && ev == S_VT-1) begin
      mst = M_IDLE; eh = 0; ev = 0;
    end else begin
      if (eh == S_HT-1) begin
        eh = 0;
        ev = (ev == S_VT-1) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
      mst = en ? M_RUN : M_DRAIN;
    end
  endtask

  task automatic chk_video();
    logic r;
    r = (mst != M_IDLE);
    chk("busy",        busy_s, r);
    chk("hcount",      h_s, r ? eh : 0);
    chk("vcount",      v_s, r ? ev : 0);
    chk("hblnk",       hb_s, r && eh >= S_HB);
    chk("hsync",       hs_s, r && eh >= S_HS && eh < S_HE);
    chk("vblnk",       vb_s, r && ev >= S_VB);
    chk("vsync",       vs_s, r && ev >= S_VS && ev < S_VE);
    chk("frame_start", fs_s, r && eh == 0 && ev == 0);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(eh == h && ev == v) && n < 2000) begin
      tick_s();
      chk_video();
      n++;
    end
    chk("run_to_reached", (eh == h && ev == v), 1);
  endtask

  // Waits for cfg_ack; reports cycles taken, model position at ack and
  // how many cycles xpos/ypos moved away from old_x/old_y before the ack.
  task automatic wait_ack(input int old_x, input int old_y,
                          output int cyc, output int ah, output int av, output int early);
    cyc = 0; ah = -1; av = -1; early = 0;
    while (cyc < 1000) begin
      tick_s();
      chk_video();
      cyc++;
      if (cfg_s.cfg_ack) begin
        ah = eh; av = ev;
        break;
      end
      if (xpos_s !== 11'(old_x) || ypos_s !== 11'(old_y)) early++;
    end
  endtask

  initial begin
    int bad_h, bad_hs, bad_hb, bad_v, nhs, cnt, ah, av, early, acks;
    rst = 1'b1; en = 1'b0; en_d = 1'b0;
    cfg_s.cfg_req = 1'b0; cfg_s.cfg_xpos = '0; cfg_s.cfg_ypos = '0;
    cfg_d.cfg_req = 1'b0; cfg_d.cfg_xpos = '0; cfg_d.cfg_ypos = '0;
    mst = M_IDLE; eh = 0; ev = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk_video();
    chk("rst_xpos", xpos_s, 0);
    chk("rst_ypos", ypos_s, 0);
    chk("rst_ack",  cfg_s.cfg_ack, 0);

    // full-size horizontal timing on the first line
    en_d = 1'b1;
    @(posedge clk); #1;
    chk("d_first_fs", fs_d, 1);
    chk("d_busy", busy_d, 1);
    bad_h = 0; bad_hs = 0; bad_hb = 0; bad_v = 0; nhs = 0;
    for (int i = 0; i < 1056; i++) begin
      if (h_d !== 11'(i) || v_d !== 11'd0) bad_h++;
      if (hs_d !== (i >= 840 && i < 968)) bad_hs++;
      if (hb_d !== (i >= 800)) bad_hb++;
      if (vb_d || vs_d || cfg_d.cfg_ack || (fs_d !== (i == 0))) bad_v++;
      if (hs_d) nhs++;
      @(posedge clk); #1;
    end
    chk("d_count_bad", bad_h, 0);
    chk("d_hsync_bad", bad_hs, 0);
    chk("d_hblnk_bad", bad_hb, 0);
    chk("d_vflags_bad", bad_v, 0);
    chk("d_hsync_width", nhs, 128);
    chk("d_line1_h", h_d, 0);
    chk("d_line1_v", v_d, 1);
    chk("d_xpos", xpos_d, 0);
    chk("d_ypos", ypos_d, 0);
    en_d = 1'b0;

    // start and frame period
    en = 1'b1;
    tick_s(); chk_video();
    chk("start_fs", fs_s, 1);
    cnt = 0;
    while (cnt < 1000) begin
      tick_s(); chk_video(); cnt++;
      if (fs_s) break;
    end
    chk("frame_period", cnt, S_HT*S_VT);

    // stop mid-frame: finishes the frame, then idles
    run_to(0, 3);
    en = 1'b0;
    run_to(S_HT-1, S_VT-1);
    chk("drain_busy", busy_s, 1);
    tick_s(); chk_video();
    chk("stop_busy", busy_s, 0);
    repeat (5) begin tick_s(); chk_video(); end

    // drain interrupted by en: no restart, frame_start at next 0/0
    en = 1'b1;
    tick_s(); chk_video();
    run_to(0, 3);
    en = 1'b0;
    run_to(0, 6);
    en = 1'b1;
    run_to(S_HT-1, S_VT-1);
    tick_s(); chk_video();
    chk("resume_fs", fs_s, 1);
    chk("resume_busy", busy_s, 1);

    // position update while running commits at start of vblank
    run_to(0, 1);
    cfg_s.cfg_xpos = 11'd400; cfg_s.cfg_ypos = 11'd200; cfg_s.cfg_req = 1'b1;
    wait_ack(0, 0, cnt, ah, av, early);
    cfg_s.cfg_req = 1'b0;
    chk("run_ack_h", ah, 1);
    chk("run_ack_v", av, S_VB);
    chk("run_no_early_update", early, 0);
    chk("run_xpos", xpos_s, 400);
    chk("run_ypos", ypos_s, 200);
    tick_s(); chk_video();
    chk("run_ack_pulse", cfg_s.cfg_ack, 0);
    chk("run_xpos_hold", xpos_s, 400);

    // request accepted on the commit cycle waits a whole frame
    run_to(0, S_VB);
    cfg_s.cfg_xpos = 11'd7; cfg_s.cfg_ypos = 11'd9; cfg_s.cfg_req = 1'b1;
    wait_ack(400, 200, cnt, ah, av, early);
    cfg_s.cfg_req = 1'b0;
    chk("late_latency", cnt, S_HT*S_VT + 1);
    chk("late_ack_v", av, S_VB);
    chk("late_no_early_update", early, 0);
    chk("late_xpos", xpos_s, 7);
    chk("late_ypos", ypos_s, 9);

    // idle update acks two cycles after the request
    en = 1'b0;
    run_to(S_HT-1, S_VT-1);
    tick_s(); chk_video();
    cfg_s.cfg_xpos = 11'd123; cfg_s.cfg_ypos = 11'd45; cfg_s.cfg_req = 1'b1;
    tick_s(); chk_video();
    chk("idle_ack_c1", cfg_s.cfg_ack, 0);
    chk("idle_xpos_c1", xpos_s, 7);
    tick_s(); chk_video();
    chk("idle_ack_c2", cfg_s.cfg_ack, 1);
    chk("idle_xpos", xpos_s, 123);
    chk("idle_ypos", ypos_s, 45);
    cfg_s.cfg_req = 1'b0;
    tick_s(); chk_video();
    chk("idle_ack_c3", cfg_s.cfg_ack, 0);
    chk("idle_xpos_hold", xpos_s, 123);

    // reset with a request pending discards it
    en = 1'b1;
    tick_s(); chk_video();
    run_to(0, 2);
    cfg_s.cfg_xpos = 11'd55; cfg_s.cfg_ypos = 11'd66; cfg_s.cfg_req = 1'b1;
    tick_s(); chk_video();
    cfg_s.cfg_req = 1'b0;
    repeat (5) begin tick_s(); chk_video(); end
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mst = M_IDLE; eh = 0; ev = 0;
    chk_video();
    chk("rst_mid_xpos", xpos_s, 0);
    chk("rst_mid_ypos", ypos_s, 0);
    acks = 0;
    repeat (10) begin
      tick_s(); chk_video();
      if (cfg_s.cfg_ack) acks++;
    end
    chk("rst_mid_no_ack", acks, 0);
    chk("rst_mid_xpos_after", xpos_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
